// File: rtl/jtag_reg_access.sv
// jtag_reg_access
//   Bridges a debug-host command/response handshake onto the JTAG port of the
//   GPR file. Reads are a single cycle. Writes wait while the execute stage
//   owns the write port and are abandoned with an error after WAIT_MAX busy
//   cycles.
// Ports
//   clk, rst                 clock, async active-low reset
//   cmd_valid/ready          host command handshake
//   cmd_write/addr/wdata     command contents
//   rsp_valid/ready          host response handshake
//   rsp_rdata, rsp_err       response contents
//   ex_we_i                  execute-stage write enable (has priority)
//   jtag_we_o/addr_o/data_o  register file JTAG port
//   jtag_data_i              register file JTAG read data
module jtag_reg_access #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        ex_we_i,
  output logic        jtag_we_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_data_o,
  input  logic [31:0] jtag_data_i
);

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [4:0]          addr_q;
  logic [31:0]         data_q;
  logic [WAIT_W-1:0]   wait_q;

  // Combinational so the pulse lands in the same cycle the execute stage
  // leaves the port free; x0 is never written.
  assign jtag_we_o   = (state_q == WRITE) && (addr_q != 5'd0) && !ex_we_i;

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign jtag_addr_o = addr_q;
  assign jtag_data_o = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wait_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            addr_q      <= cmd_addr;
            data_q      <= cmd_wdata;
            wait_q      <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= cmd_write ? WRITE : READ;
          end
        end
        READ: begin
          rsp_rdata_q <= jtag_data_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        WRITE: begin
          if ((addr_q == 5'd0) || !ex_we_i) begin
            // Either nothing to write (x0) or the pulse is issued this cycle.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
            // This busy cycle is the WAIT_MAX-th one: give up.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            wait_q      <= WAIT_W'(WAIT_MAX);
            state_q     <= RESP;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_reg_access.sv
module tb_jtag_reg_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ex_we_i, jtag_we_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_data_o, jtag_data_i;

  always #5 clk = ~clk;

  jtag_reg_access #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ex_we_i(ex_we_i), .jtag_we_o(jtag_we_o),
    .jtag_addr_o(jtag_addr_o), .jtag_data_o(jtag_data_o),
    .jtag_data_i(jtag_data_i)
  );

  // Register file model: JTAG port read is combinational, x0 reads 0.
  logic [31:0] rf [32];
  int          total_we = 0;
  assign jtag_data_i = (jtag_addr_o == 5'd0) ? 32'd0 : rf[jtag_addr_o];
  always @(posedge clk) begin
    if (jtag_we_o) begin
      rf[jtag_addr_o] <= jtag_data_o;
      total_we++;
    end
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          busy;      // cycles of ex_we_i=1 after accept
    int          hold;      // cycles rsp_ready held low in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_pulses;
    int          exp_rsp_k; // cycle (1 = first after accept edge) rsp_valid seen
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d,
                              input int busy, input int hold, input logic [31:0] rd,
                              input logic er, input int pulses, input int rk);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.busy = busy; v.hold = hold;
    v.exp_rdata = rd; v.exp_err = er; v.exp_pulses = pulses; v.exp_rsp_k = rk;
    return v;
  endfunction

  task automatic wait_ready();
    int to = 0;
    @(negedge clk);
    while (!cmd_ready && to < 20) begin
      @(negedge clk);
      to++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    int   k, pulses, pulse_k, rsp_k;
    rsp_t e;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    wait_ready();
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    ex_we_i   = (v.busy > 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 1; pulses = 0; pulse_k = 0; rsp_k = 0;
    while (rsp_k == 0 && k < 60) begin
      @(negedge clk);
      ex_we_i = (k <= v.busy);
      #1;
      if (k == 1) chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      if (jtag_we_o) begin
        pulses++;
        pulse_k = k;
        chk("we_addr", 32'(jtag_addr_o), 32'(v.addr));
        chk("we_data", jtag_data_o, v.wdata);
      end
      if (rsp_valid) rsp_k = k;
      k++;
    end
    ex_we_i = 1'b0;
    chk("rsp_latency", rsp_k, v.exp_rsp_k);
    chk("we_pulses", pulses, v.exp_pulses);
    if (v.exp_pulses == 1) chk("we_cycle", pulse_k, v.busy + 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, e.rdata);
        chk("hold_err", 32'(rsp_err), 32'(e.err));
        chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_we"},        32'(jtag_we_o), 32'd0);
    chk({tag, "_addr"},      32'(jtag_addr_o), 32'd0);
    chk({tag, "_data"},      jtag_data_o, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[5] = 32'hDEAD_BEEF;

    //               wr    addr  wdata          busy hold rdata          err pul rk
    vecs[0] = mk(1'b0, 5'd5, 32'h0,          0,   0,  32'hDEAD_BEEF, 0,  0,  2);
    vecs[1] = mk(1'b1, 5'd7, 32'h1234_5678,  0,   0,  32'h0,         0,  1,  2);
    vecs[2] = mk(1'b0, 5'd7, 32'h0,          0,   0,  32'h1234_5678, 0,  0,  2);
    vecs[3] = mk(1'b1, 5'd3, 32'hA5A5_A5A5,  4,   0,  32'h0,         0,  1,  6);
    vecs[4] = mk(1'b0, 5'd3, 32'h0,          0,   0,  32'hA5A5_A5A5, 0,  0,  2);
    vecs[5] = mk(1'b1, 5'd3, 32'h1111_1111,  100, 0,  32'h0,         1,  0,  17);
    vecs[6] = mk(1'b0, 5'd3, 32'h0,          0,   0,  32'hA5A5_A5A5, 0,  0,  2);
    vecs[7] = mk(1'b1, 5'd0, 32'hFFFF_FFFF,  0,   0,  32'h0,         0,  0,  2);
    vecs[8] = mk(1'b0, 5'd0, 32'h0,          0,   0,  32'h0,         0,  0,  2);
    vecs[9] = mk(1'b0, 5'd5, 32'h0,          0,   5,  32'hDEAD_BEEF, 0,  0,  2);

    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; ex_we_i = 1'b0;

    // Reset state, held across clock edges.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    #1 chk("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 chk("rel_cmd_ready_high", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // Reset while a write is stalled by the execute stage.
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd3; cmd_wdata = 32'hBAD0_BAD0;
    ex_we_i   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("midw_no_we", 32'(jtag_we_o), 32'd0);
    end
    chk("midw_addr", 32'(jtag_addr_o), 32'd3);
    #2 rst = 1'b0;
    #1 chk_all_zero("midw_reset");
    ex_we_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_cmd(mk(1'b0, 5'd3, 32'h0, 0, 0, 32'hA5A5_A5A5, 0, 0, 2));

    chk("sb_empty", sb.size(), 32'd0);
    chk("total_we", total_we, 32'd2);
    chk("rf_x3", rf[3], 32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_reg_access.md
JTAG_REG_ACCESS -- requirements
Module: jtag_reg_access

Interface
REQ-001 Parameter WAIT_MAX, default 16: maximum consecutive core-write-busy cycles tolerated before a JTAG write is abandoned with error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  debug host presents a register command.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  5  GPR index x0..x31.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  host consumes response.
REQ-011 rsp_rdata  output  32  read data; 0 for writes.
REQ-012 rsp_err  output  1  1 = write abandoned after WAIT_MAX busy cycles.
REQ-013 ex_we_i  input  1  execute-stage register write enable; the register file gives this port priority over the JTAG port.
REQ-014 jtag_we_o  output  1  write enable to the register file's JTAG port.
REQ-015 jtag_addr_o  output  5  register file JTAG address.
REQ-016 jtag_data_o  output  32  register file JTAG write data.
REQ-017 jtag_data_i  input  32  register file JTAG read data (combinational, returns 0 for x0).

Function
REQ-018 FSM states: IDLE, READ, WRITE, RESP; exactly one state active.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch cmd_write/addr/wdata, clear the wait counter, go to READ (cmd_write=0) or WRITE (cmd_write=1).
REQ-020 cmd_ready SHALL be 0 in READ, WRITE and RESP; commands presented then are not accepted and not lost (host holds cmd_valid).
REQ-021 jtag_addr_o and jtag_data_o SHALL be registered copies of the latched address/data, valid from the cycle after acceptance until return to IDLE.
REQ-022 READ: one cycle; jtag_data_i sampled at the end of that cycle into rsp_rdata, rsp_err=0, go to RESP; rsp_valid rises 2 cycles after the accept edge.
REQ-023 WRITE, address 0: no jtag_we_o pulse; go to RESP, rsp_err=0.
REQ-024 WRITE, address != 0, ex_we_i=0: jtag_we_o=1 combinationally that cycle (exactly one cycle); go to RESP, rsp_err=0.
REQ-025 WRITE, address != 0, ex_we_i=1: jtag_we_o=0, increment the wait counter, stay in WRITE (the register file would drop a colliding JTAG write).
REQ-026 When the wait counter reaches WAIT_MAX while in WRITE: no write issued, go to RESP with rsp_err=1.
REQ-027 The wait counter SHALL be wide enough to hold WAIT_MAX without wrap.
REQ-028 jtag_we_o SHALL never be 1 outside WRITE, and at most once per command.
REQ-029 RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready; on that edge, go to IDLE with rsp_valid=0, then cmd_ready=1 the next cycle.
REQ-030 For writes, rsp_rdata SHALL be 0.
REQ-031 Back-to-back: minimum command-to-command spacing is 3 cycles for reads (accept, READ, RESP with rsp_ready=1).

Reset
REQ-032 rst=0 asynchronously forces IDLE, clears the wait counter and sets cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0.
REQ-033 cmd_ready SHALL rise at the first rising clk edge after rst deasserts.
REQ-034 Reset mid-command (READ/WRITE/RESP) SHALL abort the command with no register write and no response.

Verification
REQ-035 Read x5 while the register file holds 0xDEADBEEF in x5 -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0, jtag_we_o never 1.
REQ-036 Write x7=0x12345678, ex_we_i=0 -> single jtag_we_o pulse, addr 7, data 0x12345678; readback via read command returns 0x12345678.
REQ-037 Write x3=0xA5A5A5A5 with ex_we_i=1 for 4 cycles then 0 -> jtag_we_o pulses in the 5th WRITE cycle, rsp_err=0.
REQ-038 Write x3 with ex_we_i held 1 and WAIT_MAX=16 -> after 16 WRITE cycles rsp_err=1, no jtag_we_o pulse, x3 unchanged.
REQ-039 Write x0=0xFFFFFFFF -> no jtag_we_o, rsp_err=0; subsequent read of x0 returns 0.
REQ-040 rsp_ready held 0 for 5 cycles in RESP, then rst pulsed low mid-WRITE on the next command -> response stable for all 5 cycles; after reset all outputs 0, no write issued.
